// File: rtl/seq_divider_if.sv
// Operand/result bundle between the exponentiation stage (master) and the divider (slave).
interface seq_divider_if #(
    parameter int unsigned W = 16
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divider;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         busy;
    logic         div_by_zero;

    modport master (
        output start, dividend, divider,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divider,
        output quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, launched on a rising edge of start.
module seq_divider #(
    parameter int unsigned W = 16
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

    state_t        state_q;
    logic          start_q;
    logic [W:0]    rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  d_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  quotient_q;
    logic [W-1:0]  remainder_q;
    logic          ready_q;
    logic          busy_q;
    logic          dbz_q;

    logic          launch;
    logic [W:0]    t;
    logic [W:0]    rem_d;
    logic [W-1:0]  quo_d;

    assign launch = bus.start & ~start_q;

    always_comb begin
        t     = {rem_q[W-1:0], quo_q[W-1]};
        rem_d = t;
        quo_d = {quo_q[W-2:0], 1'b0};
        // rem_q[W] is always 0 in practice; folding it in keeps the compare exact.
        if (rem_q[W] || (t >= {1'b0, d_q})) begin
            rem_d = t - {1'b0, d_q};
            quo_d = {quo_q[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state_q)
                IDLE, DONE: begin
                    if (launch) begin
                        quo_q   <= bus.dividend;
                        d_q     <= bus.divider;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.divider != '0) ? RUN : ZERO;
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(W)) begin
                        quotient_q  <= quo_q;
                        remainder_q <= rem_q[W-1:0];
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ZERO: begin
                    // Two cycles in ZERO so ready lands at E0+2.
                    if (cnt_q == CW'(1)) begin
                        quotient_q  <= '1;
                        remainder_q <= quo_q;
                        dbz_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at W=16.
module tb_seq_divider;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_divider_if #(.W(16)) bus ();

    seq_divider #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!bus.ready && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_quo"},   32'(bus.quotient), 0);
        check_eq({tag, "_rem"},   32'(bus.remainder), 0);
        check_eq({tag, "_ready"}, 32'(bus.ready), 0);
        check_eq({tag, "_busy"},  32'(bus.busy), 0);
        check_eq({tag, "_dbz"},   32'(bus.div_by_zero), 0);
    endtask

    // Single-cycle start pulse, then wait for the result.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] exp_q, input logic [15:0] exp_r,
                          input logic exp_dbz, input int exp_lat);
        int cyc;
        bus.dividend = dvd;
        bus.divider  = dvs;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        check_eq({tag, "_busy_e0"},  32'(bus.busy), 1);
        check_eq({tag, "_ready_e0"}, 32'(bus.ready), 0);
        wait_ready(cyc);
        check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_quo"}, 32'(bus.quotient), 32'(exp_q));
        check_eq({tag, "_rem"}, 32'(bus.remainder), 32'(exp_r));
        check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        check_eq({tag, "_busy_done"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int cyc;
        int bad;
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divider  = '0;

        // Reset under random stimulus.
        for (int i = 0; i < 5; i++) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = 16'($urandom);
            bus.divider  = 16'($urandom);
            tick();
        end
        check_outputs_zero("reset");

        // start rises in the last reset cycle and is held for 40 cycles.
        bus.dividend = 16'd1000;
        bus.divider  = 16'd7;
        bus.start    = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_wins_busy", 32'(bus.busy), 0);
        tick();
        check_eq("held_busy_e0", 32'(bus.busy), 1);
        wait_ready(cyc);
        check_eq("held_lat", 32'(cyc), 17);
        check_eq("held_quo", 32'(bus.quotient), 142);
        check_eq("held_rem", 32'(bus.remainder), 6);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.ready || bus.busy) bad++;
        end
        check_eq("held_single_op", 32'(bad), 0);
        bus.start = 1'b0;
        tick();

        run_op("max_by_1",  16'd65535, 16'd1,     16'd65535, 16'd0, 1'b0, 17);
        run_op("small_num", 16'd5,     16'd9,     16'd0,     16'd5, 1'b0, 17);
        run_op("equal",     16'd65535, 16'd65535, 16'd1,     16'd0, 1'b0, 17);
        run_op("zero_num",  16'd0,     16'd3,     16'd0,     16'd0, 1'b0, 17);
        run_op("div0",      16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 2);
        run_op("after0",    16'd10,    16'd3,     16'd3,     16'd1, 1'b0, 17);

        // Second pulse at E0+5 must be dropped, not queued.
        bus.dividend = 16'd200;
        bus.divider  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.dividend = 16'd9;
        bus.divider  = 16'd2;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        cyc = 5;
        while (!bus.ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("ignore_lat", 32'(cyc), 17);
        check_eq("ignore_quo", 32'(bus.quotient), 28);
        check_eq("ignore_rem", 32'(bus.remainder), 4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.ready || bus.busy) bad++;
        end
        check_eq("ignore_not_queued", 32'(bad), 0);

        // Back-to-back: the second launch is on the edge after ready rises.
        run_op("b2b_a", 16'd300, 16'd11, 16'd27, 16'd3, 1'b0, 17);
        run_op("b2b_b", 16'd77,  16'd5,  16'd15, 16'd2, 1'b0, 17);

        // Reset at E0+8 discards the operation.
        bus.dividend = 16'd1000;
        bus.divider  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("midrun_rst");
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.ready || bus.busy) bad++;
        end
        check_eq("midrun_no_ready", 32'(bad), 0);
        run_op("post_rst", 16'd100, 16'd9, 16'd11, 16'd1, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
